// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end that shares one sequential 4x4
// shift-add multiplier among NREQ requesters. The winning requester's
// operands are latched, the multiplier is started and its done is awaited
// (with a stale-done mask and a timeout). The 9-bit product is then
// returned, tagged with the requester id.
module mult_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned IDW      = 2,
    parameter int unsigned MIN_WAIT = 2,
    parameter int unsigned TIMEOUT  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              resp_valid,
    output logic [IDW-1:0]    resp_id,
    output logic [8:0]        resp_prod,
    output logic              resp_err,
    output logic              mul_st,
    output logic [3:0]        mul_mplier,
    output logic [3:0]        mul_mcand,
    input  logic [8:0]        mul_prod,
    input  logic              mul_done
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] MIN_CNT  = CW'(MIN_WAIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  cur_id;
    logic [CW-1:0]   cnt;
    logic [IDW-1:0]  win;
    logic            found;
    logic [3:0]      sel_a;
    logic [3:0]      sel_b;

    // Round-robin search: first set request after the last-served slot.
    always_comb begin
        int unsigned idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!found && req[idx[IDW-1:0]]) begin
                found = 1'b1;
                win   = idx[IDW-1:0];
            end
        end
    end

    // Operand mux for the current winner.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win) begin
                sel_a = req_a[4*i +: 4];
                sel_b = req_b[4*i +: 4];
            end
        end
    end

    // Grant is combinational from IDLE and the live request vector; it is
    // suppressed while reset is asserted so gnt reads zero during reset.
    always_comb begin
        gnt = '0;
        if (state == S_IDLE && !rst && found) begin
            gnt[win] = 1'b1;
        end
    end

    // Control FSM; every output other than gnt is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= IDW'(NREQ - 1);
            cur_id     <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_prod  <= '0;
            resp_err   <= 1'b0;
            mul_st     <= 1'b1;
            mul_mplier <= '0;
            mul_mcand  <= '0;
        end else begin
            resp_valid <= 1'b0;
            mul_st     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        cur_id     <= win;
                        mul_mplier <= sel_a;
                        mul_mcand  <= sel_b;
                        mul_st     <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    // A done seen before MIN_WAIT may be left over from the
                    // previous operation; an accepted done beats the timeout.
                    if (cnt >= MIN_CNT && mul_done) begin
                        resp_prod  <= mul_prod;
                        resp_err   <= 1'b0;
                        resp_id    <= cur_id;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else if (cnt == LAST_CNT) begin
                        resp_prod  <= '0;
                        resp_err   <= 1'b1;
                        resp_id    <= cur_id;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    ptr   <= cur_id;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
